// File: rtl/timer_counter_core_pkg.sv
// -----------------------------------------------------------------------------
// timer_counter_core_pkg
//
// Purpose:
//   Shared definitions for the 8-bit timer counting engine.
//   - Clock-select codes carried on the Cks field.
//   - Prescaler counter width.
//   - Default TCNT width and its all-ones value.
//   - Helper that turns a clock-select code into the prescaler compare mask.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package timer_counter_core_pkg;

  // Clock-select encodings: the tick rate is PCLK divided by 2^(Cks+1).
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  // The prescaler must reach 15 for the slowest (PCLK/16) setting.
  localparam int DIV_CNT_W = 4;

  // Default counter width and its all-ones value.
  localparam int                  DATA_WIDTH_DEF = 8;
  localparam logic [DATA_WIDTH_DEF-1:0] TCNT_MAX = '1;

  // Compare mask for the prescaler: 2^(Cks+1)-1. A tick is issued whenever
  // every bit under the mask is set, which happens once every 2^(Cks+1)
  // increments of the free-running prescaler counter.
  function automatic logic [DIV_CNT_W-1:0] cks_mask(input cks_e cks);
    logic [DIV_CNT_W-1:0] m;
    m = 4'b0001;
    unique case (cks)
      CKS_DIV2:  m = 4'b0001;
      CKS_DIV4:  m = 4'b0011;
      CKS_DIV8:  m = 4'b0111;
      CKS_DIV16: m = 4'b1111;
      default:   m = 4'b0001;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
//
// Purpose:
//   PCLK prescaler of the timer. Owns the 4-bit div_cnt and produces the
//   combinational tick_int strobe that advances TCNT in the counter core.
//
//   div_cnt increments every PCLK while counting is enabled and no load is in
//   progress; it is cleared whenever counting is disabled or a load occurs,
//   so the first tick after enable/load arrives on the N-th enabled cycle
//   with N = 2^(Cks+1). A Cks change mid-count does not clear div_cnt; the
//   new mask simply applies from the next cycle.
//
// Ports:
//   PCLK          in   system clock
//   PRESET_n      in   asynchronous active-low reset
//   Cks[1:0]      in   clock select (00=/2, 01=/4, 10=/8, 11=/16)
//   count_enable  in   1 = counting active
//   Load_Tdr      in   one-cycle load strobe (restarts the prescaler)
//   tick_int      out  one-PCLK count strobe (combinational)
// -----------------------------------------------------------------------------
module timer_prescaler
  import timer_counter_core_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESET_n,
  input  logic [1:0] Cks,
  input  logic       count_enable,
  input  logic       Load_Tdr,
  output logic       tick_int
);

  logic [DIV_CNT_W-1:0] div_cnt;
  logic [DIV_CNT_W-1:0] mask;

  assign mask = cks_mask(cks_e'(Cks));

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      div_cnt <= '0;
    end else if (!count_enable || Load_Tdr) begin
      div_cnt <= '0;
    end else begin
      // Wraps naturally at 16; every mask width divides 16 evenly, so the
      // tick period stays exact across the wrap.
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick_int = count_enable && ((div_cnt & mask) == mask);

endmodule

// File: rtl/timer_counter_core.sv
// -----------------------------------------------------------------------------
// timer_counter_core
//
// Purpose:
//   Counting engine of the 8-bit timer. Consumes the control signals driven by
//   the TCR/TDR logic, runs the PCLK prescaler, maintains TCNT and returns
//   one-cycle overflow/underflow pulses to the status-register (TSR) logic.
//
//   Update priority on each PCLK edge:
//     1. Load_Tdr         : TCNT <= count_start_value, no pulses
//                           (beats a coincident tick, enabled or not)
//     2. tick, counting up: all-ones wraps with ovf_pulse, else +1
//     3. tick, counting dn: zero wraps with udf_pulse, else -1
//     4. otherwise        : hold
//   ovf_pulse/udf_pulse are registered and coincide with the cycle TCNT first
//   shows the wrapped value; they are mutually exclusive.
//
// Configuration macro:
//   TIMER_AUTO_RELOAD_EN  when defined, a wrap reloads count_start_value
//                         instead of 0 (up) / all-ones (down). The wrap
//                         condition and the pulses are unchanged. When
//                         undefined the counter wraps freely.
//
// Ports:
//   PCLK               in   system/APB clock, the only clock
//   PRESET_n           in   asynchronous active-low reset
//   Cks[1:0]           in   clock select (00=/2, 01=/4, 10=/8, 11=/16)
//   Load_Tdr           in   one-cycle load strobe
//   count_start_value  in   value loaded into TCNT (and reload value)
//   count_up_down      in   0 = count up, 1 = count down
//   count_enable       in   1 = counting active
//   TCNT               out  current counter value
//   cnt_tick           out  registered prescaler tick, one PCLK wide
//   ovf_pulse          out  one-cycle pulse on up-count wrap
//   udf_pulse          out  one-cycle pulse on down-count wrap
// -----------------------------------------------------------------------------
module timer_counter_core
  import timer_counter_core_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic [1:0]            Cks,
  input  logic                  Load_Tdr,
  input  logic [DATA_WIDTH-1:0] count_start_value,
  input  logic                  count_up_down,
  input  logic                  count_enable,
  output logic [DATA_WIDTH-1:0] TCNT,
  output logic                  cnt_tick,
  output logic                  ovf_pulse,
  output logic                  udf_pulse
);

  localparam logic [DATA_WIDTH-1:0] CNT_ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] CNT_ZERO     = '0;

  logic                  tick_int;
  logic [DATA_WIDTH-1:0] wrap_up_val;
  logic [DATA_WIDTH-1:0] wrap_dn_val;
  logic [DATA_WIDTH+1:0] step_res;   // {ovf, udf, next count}

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  timer_prescaler u_prescaler (
    .PCLK         (PCLK),
    .PRESET_n     (PRESET_n),
    .Cks          (Cks),
    .count_enable (count_enable),
    .Load_Tdr     (Load_Tdr),
    .tick_int     (tick_int)
  );

  // Value written into TCNT when the count wraps.
`ifdef TIMER_AUTO_RELOAD_EN
  assign wrap_up_val = count_start_value;
  assign wrap_dn_val = count_start_value;
`else
  assign wrap_up_val = CNT_ZERO;
  assign wrap_dn_val = CNT_ALL_ONES;
`endif

  // One modulo-2^DATA_WIDTH count step. Returns {ovf, udf, next}; the wrap is
  // detected on the current value so the reload choice never affects it.
  function automatic logic [DATA_WIDTH+1:0] step_count(
    input logic [DATA_WIDTH-1:0] cur,
    input logic                  down,
    input logic [DATA_WIDTH-1:0] up_wrap,
    input logic [DATA_WIDTH-1:0] dn_wrap
  );
    logic [DATA_WIDTH-1:0] nxt;
    logic                  ovf;
    logic                  udf;
    nxt = cur;
    ovf = 1'b0;
    udf = 1'b0;
    if (!down) begin
      if (cur == CNT_ALL_ONES) begin
        nxt = up_wrap;
        ovf = 1'b1;
      end else begin
        nxt = cur + 1'b1;
      end
    end else begin
      if (cur == CNT_ZERO) begin
        nxt = dn_wrap;
        udf = 1'b1;
      end else begin
        nxt = cur - 1'b1;
      end
    end
    return {ovf, udf, nxt};
  endfunction

  assign step_res = step_count(TCNT, count_up_down, wrap_up_val, wrap_dn_val);

  // ---------------------------------------------------------------------------
  // Counter and pulse registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      TCNT      <= '0;
      cnt_tick  <= 1'b0;
      ovf_pulse <= 1'b0;
      udf_pulse <= 1'b0;
    end else begin
      cnt_tick  <= tick_int;
      ovf_pulse <= 1'b0;
      udf_pulse <= 1'b0;
      if (Load_Tdr) begin
        TCNT <= count_start_value;
      end else if (tick_int) begin
        TCNT      <= step_res[DATA_WIDTH-1:0];
        udf_pulse <= step_res[DATA_WIDTH];
        ovf_pulse <= step_res[DATA_WIDTH+1];
      end
    end
  end

endmodule

// File: tb/tb_timer_counter_core.sv
// -----------------------------------------------------------------------------
// tb_timer_counter_core
//
// Self-checking bench for timer_counter_core. Each scenario task loads the
// counter, pushes the TCNT changes it expects (value, pulses and the number of
// PCLK cycles since the previous change) into a scoreboard queue, and the
// monitor task pops and compares every time TCNT moves. Outputs are sampled
// on the falling edge of PCLK. Expected values follow TIMER_AUTO_RELOAD_EN.
// -----------------------------------------------------------------------------
module tb_timer_counter_core;

  localparam int W = 8;

  logic         PCLK;
  logic         PRESET_n;
  logic [1:0]   Cks;
  logic         Load_Tdr;
  logic [W-1:0] count_start_value;
  logic         count_up_down;
  logic         count_enable;
  logic [W-1:0] TCNT;
  logic         cnt_tick;
  logic         ovf_pulse;
  logic         udf_pulse;

  typedef struct {
    logic [W-1:0] tcnt;
    logic         ovf;
    logic         udf;
    int           gap;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] prev_tcnt;
  int           cyc;
  int           checks = 0;
  int           errors = 0;

  timer_counter_core #(.DATA_WIDTH(W)) dut (
    .PCLK              (PCLK),
    .PRESET_n          (PRESET_n),
    .Cks               (Cks),
    .Load_Tdr          (Load_Tdr),
    .count_start_value (count_start_value),
    .count_up_down     (count_up_down),
    .count_enable      (count_enable),
    .TCNT              (TCNT),
    .cnt_tick          (cnt_tick),
    .ovf_pulse         (ovf_pulse),
    .udf_pulse         (udf_pulse)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Drive a one-cycle load; returns on the falling edge right after the load
  // edge, with Load_Tdr already deasserted and the prescaler at zero.
  task automatic do_load(input logic [W-1:0] val, input logic [1:0] cks,
                         input logic dir, input logic en);
    @(negedge PCLK);
    Load_Tdr          = 1'b1;
    count_start_value = val;
    Cks               = cks;
    count_up_down     = dir;
    count_enable      = en;
    @(negedge PCLK);
    Load_Tdr = 1'b0;
  endtask

  task automatic expect_chg(input logic [W-1:0] v, input logic o,
                            input logic u, input int gap);
    exp_t e;
    e.tcnt = v; e.ovf = o; e.udf = u; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic sb_start();
    prev_tcnt = TCNT;
    cyc       = 0;
  endtask

  // Monitor: pops one expectation per TCNT change, bounded by a cycle budget.
  task automatic run_sb(input int budget);
    exp_t e;
    int   waited;
    waited = 0;
    while (sb.size() > 0 && waited < budget) begin
      @(negedge PCLK);
      waited++;
      cyc++;
      checks++;
      if (ovf_pulse === 1'b1 && udf_pulse === 1'b1) begin
        errors++;
        $display("FAIL both_pulses: ovf=%b udf=%b required not both high", ovf_pulse, udf_pulse);
      end
      if (TCNT !== prev_tcnt) begin
        e = sb.pop_front();
        checks++;
        if (TCNT !== e.tcnt) begin
          errors++;
          $display("FAIL tcnt_value: got %0h expected %0h", TCNT, e.tcnt);
        end
        checks++;
        if (ovf_pulse !== e.ovf || udf_pulse !== e.udf) begin
          errors++;
          $display("FAIL pulses at tcnt=%0h: got ovf=%b udf=%b expected ovf=%b udf=%b",
                   TCNT, ovf_pulse, udf_pulse, e.ovf, e.udf);
        end
        checks++;
        if (cyc != e.gap) begin
          errors++;
          $display("FAIL tick_period at tcnt=%0h: got %0d cycles expected %0d", TCNT, cyc, e.gap);
        end
        checks++;
        if (cnt_tick !== 1'b1) begin
          errors++;
          $display("FAIL cnt_tick at tcnt=%0h: got %b expected 1", TCNT, cnt_tick);
        end
        prev_tcnt = TCNT;
        cyc       = 0;
      end else begin
        checks++;
        if (ovf_pulse !== 1'b0 || udf_pulse !== 1'b0) begin
          errors++;
          $display("FAIL stray_pulse at tcnt=%0h: got ovf=%b udf=%b expected 0", TCNT, ovf_pulse, udf_pulse);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_timeout: %0d expected changes still pending after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    // Power-on reset state, before any clock edge.
    #1;
    checks++;
    if (TCNT !== 8'h00 || cnt_tick !== 1'b0 || ovf_pulse !== 1'b0 || udf_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got tcnt=%0h tick=%b ovf=%b udf=%b expected all 0",
               TCNT, cnt_tick, ovf_pulse, udf_pulse);
    end
    @(negedge PCLK);
    PRESET_n = 1'b1;

    // Asynchronous reset in the middle of a count.
    do_load(8'h37, 2'b11, 1'b0, 1'b1);
    repeat (3) @(negedge PCLK);
    checks++;
    if (TCNT !== 8'h37) begin
      errors++;
      $display("FAIL pre_reset_tcnt: got %0h expected 37", TCNT);
    end
    #3;
    PRESET_n = 1'b0;
    #1;
    checks++;
    if (TCNT !== 8'h00 || cnt_tick !== 1'b0 || ovf_pulse !== 1'b0 || udf_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got tcnt=%0h tick=%b ovf=%b udf=%b expected all 0",
               TCNT, cnt_tick, ovf_pulse, udf_pulse);
    end
    @(negedge PCLK);
    PRESET_n = 1'b1;
    Cks      = 2'b00;
    // Counting resumes only after a full prescaler period.
    sb_start();
    expect_chg(8'h01, 1'b0, 1'b0, 2);
    expect_chg(8'h02, 1'b0, 1'b0, 2);
    run_sb(20);
  endtask

  task automatic test_up_wrap();
    do_load(8'hFD, 2'b00, 1'b0, 1'b1);
    checks++;
    if (TCNT !== 8'hFD) begin
      errors++;
      $display("FAIL load_fd: got %0h expected fd", TCNT);
    end
    sb_start();
    expect_chg(8'hFE, 1'b0, 1'b0, 2);
    expect_chg(8'hFF, 1'b0, 1'b0, 2);
`ifdef TIMER_AUTO_RELOAD_EN
    expect_chg(8'hFD, 1'b1, 1'b0, 2);
    expect_chg(8'hFE, 1'b0, 1'b0, 2);
`else
    expect_chg(8'h00, 1'b1, 1'b0, 2);
    expect_chg(8'h01, 1'b0, 1'b0, 2);
`endif
    run_sb(30);
  endtask

  task automatic test_down_wrap();
    do_load(8'h02, 2'b11, 1'b1, 1'b1);
    sb_start();
    expect_chg(8'h01, 1'b0, 1'b0, 16);
    expect_chg(8'h00, 1'b0, 1'b0, 16);
`ifdef TIMER_AUTO_RELOAD_EN
    expect_chg(8'h02, 1'b0, 1'b1, 16);
    expect_chg(8'h01, 1'b0, 1'b0, 16);
`else
    expect_chg(8'hFF, 1'b0, 1'b1, 16);
    expect_chg(8'hFE, 1'b0, 1'b0, 16);
`endif
    run_sb(100);
  endtask

  task automatic test_load_collision();
    // Preload all-ones so a tick that slipped past the load would also wrap.
    do_load(8'hFF, 2'b01, 1'b0, 1'b1);
    repeat (3) @(negedge PCLK);
    // Prescaler now sits on its tick cycle; land a load on top of it.
    Load_Tdr          = 1'b1;
    count_start_value = 8'h80;
    @(negedge PCLK);
    checks++;
    if (TCNT !== 8'h80) begin
      errors++;
      $display("FAIL load_collision_tcnt: got %0h expected 80", TCNT);
    end
    checks++;
    if (ovf_pulse !== 1'b0 || udf_pulse !== 1'b0) begin
      errors++;
      $display("FAIL load_collision_pulse: got ovf=%b udf=%b expected 0", ovf_pulse, udf_pulse);
    end
    Load_Tdr = 1'b0;
    sb_start();
    expect_chg(8'h81, 1'b0, 1'b0, 4);
    expect_chg(8'h82, 1'b0, 1'b0, 4);
    run_sb(20);
  endtask

  task automatic test_enable_gating();
    do_load(8'h10, 2'b01, 1'b0, 1'b1);
    repeat (2) @(negedge PCLK);
    count_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      checks++;
      if (TCNT !== 8'h10 || cnt_tick !== 1'b0 || ovf_pulse !== 1'b0 || udf_pulse !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold cycle %0d: got tcnt=%0h tick=%b ovf=%b udf=%b expected 10/0/0/0",
                 i, TCNT, cnt_tick, ovf_pulse, udf_pulse);
      end
    end
    Cks          = 2'b01;
    count_enable = 1'b1;
    sb_start();
    expect_chg(8'h11, 1'b0, 1'b0, 4);
    run_sb(12);
  endtask

  task automatic test_direction_change();
    do_load(8'h05, 2'b10, 1'b0, 1'b1);
    sb_start();
    expect_chg(8'h06, 1'b0, 1'b0, 8);
    run_sb(20);
    count_up_down = 1'b1;
    expect_chg(8'h05, 1'b0, 1'b0, 8);
    expect_chg(8'h04, 1'b0, 1'b0, 8);
    run_sb(40);
    count_up_down = 1'b0;
  endtask

  task automatic test_wrap_value();
    do_load(8'hF0, 2'b00, 1'b0, 1'b1);
    sb_start();
    for (int v = 8'hF1; v <= 8'hFF; v++) expect_chg(v[W-1:0], 1'b0, 1'b0, 2);
`ifdef TIMER_AUTO_RELOAD_EN
    expect_chg(8'hF0, 1'b1, 1'b0, 2);
    expect_chg(8'hF1, 1'b0, 1'b0, 2);
`else
    expect_chg(8'h00, 1'b1, 1'b0, 2);
    expect_chg(8'h01, 1'b0, 1'b0, 2);
`endif
    run_sb(60);
  endtask

  initial begin
    PRESET_n          = 1'b0;
    Cks               = 2'b00;
    Load_Tdr          = 1'b0;
    count_start_value = '0;
    count_up_down     = 1'b0;
    count_enable      = 1'b0;
    prev_tcnt         = '0;
    cyc               = 0;

    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_collision();
    test_enable_gating();
    test_direction_change();
    test_wrap_value();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
